wb_arbiter: RTL and testbench

//  Round-robin Wishbone classic arbiter: NM initiators share one target port.

---
 rtl/wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone classic arbiter: NM initiators onto one target port.
// Grant is locked for the whole cycle; a watchdog turns a hung target into err.
module wb_arbiter #(
  parameter int NM     = 3,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int SW     = DW >> 3,
  parameter int TO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW*NM-1:0] s_wb_adr,
  input  logic [SW*NM-1:0] s_wb_sel,
  input  logic [NM-1:0]    s_wb_we,
  input  logic [DW*NM-1:0] s_wb_dat_i,
  output logic [DW*NM-1:0] s_wb_dat_o,
  input  logic [NM-1:0]    s_wb_cyc,
  input  logic [NM-1:0]    s_wb_stb,
  output logic [NM-1:0]    s_wb_ack,
  output logic [NM-1:0]    s_wb_err,
  output logic [AW-1:0]    m_wb_adr,
  output logic [SW-1:0]    m_wb_sel,
  output logic             m_wb_we,
  output logic [DW-1:0]    m_wb_dat_o,
  input  logic [DW-1:0]    m_wb_dat_i,
  output logic             m_wb_cyc,
  output logic             m_wb_stb,
  input  logic             m_wb_ack,
  input  logic             m_wb_err
);

  localparam int GW = $clog2(NM);
  localparam int WW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [GW-1:0] LAST_RST = GW'(NM - 1);
  localparam logic [WW-1:0] WD_LIM   = WW'(TO_CYC);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [GW-1:0] r_gnt;
  logic [GW-1:0] r_last;
  logic [GW-1:0] w_gnt_nx;
  logic [GW-1:0] w_last_nx;
  logic [GW-1:0] w_win;
  logic          w_any;
  logic [WW-1:0] r_wd_cnt;
  logic [WW-1:0] w_wd_nx;

  logic [AW-1:0] w_adr;
  logic [SW-1:0] w_sel;
  logic          w_we;
  logic [DW-1:0] w_dat;
  logic          w_cyc;
  logic          w_stb;
  logic          w_busy;
  logic          w_wd_hit;

  // Scan downwards so the closest requester after r_last wins.
  always_comb begin
    w_win = r_last;
    w_any = 1'b0;
    for (int k = NM; k >= 1; k--) begin
      int idx;
      idx = int'(r_last) + k;
      if (idx >= NM) idx = idx - NM;
      if (s_wb_cyc[idx]) begin
        w_win = GW'(idx);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_adr = '0;
    w_sel = '0;
    w_we  = 1'b0;
    w_dat = '0;
    w_cyc = 1'b0;
    w_stb = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (GW'(i) == r_gnt) begin
        w_adr = s_wb_adr[i*AW +: AW];
        w_sel = s_wb_sel[i*SW +: SW];
        w_we  = s_wb_we[i];
        w_dat = s_wb_dat_i[i*DW +: DW];
        w_cyc = s_wb_cyc[i];
        w_stb = s_wb_stb[i];
      end
    end
  end

  assign w_busy   = (r_state == BUSY);
  assign w_wd_hit = (TO_CYC != 0) && w_busy && (r_wd_cnt == WD_LIM);

  assign m_wb_adr   = w_adr;
  assign m_wb_sel   = w_sel;
  assign m_wb_dat_o = w_dat;
  assign m_wb_we    = w_busy & w_we;
  assign m_wb_cyc   = w_busy & w_cyc;
  assign m_wb_stb   = w_busy & w_stb & ~w_wd_hit;
  assign s_wb_dat_o = {NM{m_wb_dat_i}};

  // A real ack beats a simultaneous timeout.
  always_comb begin
    s_wb_ack = '0;
    s_wb_err = '0;
    for (int i = 0; i < NM; i++) begin
      if (w_busy && (GW'(i) == r_gnt)) begin
        s_wb_ack[i] = m_wb_ack;
        s_wb_err[i] = m_wb_err | (w_wd_hit & ~m_wb_ack);
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_last_nx  = r_last;
    w_wd_nx    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nx = BUSY;
          w_gnt_nx   = w_win;
          w_last_nx  = w_win;
        end
      end
      BUSY: begin
        if (!w_cyc) w_state_nx = IDLE;
        if ((TO_CYC != 0) && !w_wd_hit && w_stb &&
            !m_wb_ack && !m_wb_err)
          w_wd_nx = r_wd_cnt + WW'(1);
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_last   <= LAST_RST;
      r_wd_cnt <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_gnt    <= w_gnt_nx;
      r_last   <= w_last_nx;
      r_wd_cnt <= w_wd_nx;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: randomized transfers against a round-robin
// reference model, plus lock, watchdog, error and reset scenarios.
module tb_wb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [95:0]  s_wb_adr;
  logic [11:0]  s_wb_sel;
  logic [2:0]   s_wb_we;
  logic [95:0]  s_wb_dat_i;
  logic [95:0]  s_wb_dat_o;
  logic [2:0]   s_wb_cyc;
  logic [2:0]   s_wb_stb;
  logic [2:0]   s_wb_ack;
  logic [2:0]   s_wb_err;
  logic [31:0]  m_wb_adr;
  logic [3:0]   m_wb_sel;
  logic         m_wb_we;
  logic [31:0]  m_wb_dat_o;
  logic [31:0]  m_wb_dat_i;
  logic         m_wb_cyc;
  logic         m_wb_stb;
  logic         m_wb_ack;
  logic         m_wb_err;

  int checks   = 0;
  int failures = 0;
  int m_last;

  wb_arbiter #(.NM(3), .AW(32), .DW(32), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .s_wb_adr(s_wb_adr), .s_wb_sel(s_wb_sel), .s_wb_we(s_wb_we),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb),
    .s_wb_ack(s_wb_ack), .s_wb_err(s_wb_err),
    .m_wb_adr(m_wb_adr), .m_wb_sel(m_wb_sel), .m_wb_we(m_wb_we),
    .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb),
    .m_wb_ack(m_wb_ack), .m_wb_err(m_wb_err)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(int last, logic [2:0] req);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic load_init(input int i);
    s_wb_adr[i*32 +: 32]   = {2'(i), 30'($urandom)};
    s_wb_sel[i*4 +: 4]     = 4'($urandom);
    s_wb_we[i]             = 1'($urandom);
    s_wb_dat_i[i*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_wb_cyc = '0; s_wb_stb = '0; s_wb_we = '0;
    m_wb_ack = 1'b0; m_wb_err = 1'b0; m_wb_dat_i = '0;
    for (int i = 0; i < 3; i++) load_init(i);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_last = 2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_wb_cyc = 3'b111; s_wb_stb = 3'b111; s_wb_we = 3'b111;
    m_wb_ack = 1'b1; m_wb_err = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({m_wb_cyc, m_wb_stb, m_wb_we} !== 3'b000) begin
      failures++;
      $display("FAIL reset_m got=%b exp=000", {m_wb_cyc, m_wb_stb, m_wb_we});
    end
    checks++;
    if ({s_wb_ack, s_wb_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_s got=%b exp=0", {s_wb_ack, s_wb_err});
    end
  endtask

  task automatic test_latency();
    logic [31:0] a;
    do_reset();
    s_wb_cyc[1] = 1'b1; s_wb_stb[1] = 1'b1;
    a = s_wb_adr[63:32];
    @(negedge clk);
    checks++;
    if (m_wb_cyc !== 1'b0) begin
      failures++;
      $display("FAIL lat_c0 got=%b exp=0", m_wb_cyc);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (m_wb_cyc !== 1'b1 || m_wb_adr !== a) begin
      failures++;
      $display("FAIL lat_c1 got=%b/%h exp=1/%h", m_wb_cyc, m_wb_adr, a);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (s_wb_ack !== 3'b000) begin
      failures++;
      $display("FAIL lat_c2 got=%b exp=000", s_wb_ack);
    end
    @(posedge clk); @(negedge clk);
    m_wb_ack = 1'b1; #1;
    checks++;
    if (s_wb_ack !== 3'b010) begin
      failures++;
      $display("FAIL lat_ack got=%b exp=010", s_wb_ack);
    end
    @(posedge clk); #1;
    m_wb_ack = 1'b0; s_wb_cyc = '0; s_wb_stb = '0;
  endtask

  // Serves every initiator in req with one single transfer, starting in IDLE.
  task automatic serve(input logic [2:0] req0);
    logic [2:0]  req;
    logic [31:0] d;
    int          w;
    req = req0;
    for (int i = 0; i < 3; i++)
      if (req[i]) begin
        load_init(i);
        s_wb_cyc[i] = 1'b1; s_wb_stb[i] = 1'b1;
      end
    while (req != 3'b000) begin
      @(negedge clk);
      checks++;
      if (m_wb_cyc !== 1'b0) begin
        failures++;
        $display("FAIL idle_gap got=%b exp=0", m_wb_cyc);
      end
      @(posedge clk); #1;
      w = rr_pick(m_last, req);
      @(negedge clk);
      checks++;
      if (m_wb_cyc !== 1'b1 || m_wb_stb !== 1'b1 ||
          m_wb_adr !== s_wb_adr[w*32 +: 32] ||
          m_wb_sel !== s_wb_sel[w*4 +: 4] ||
          m_wb_we !== s_wb_we[w] ||
          m_wb_dat_o !== s_wb_dat_i[w*32 +: 32]) begin
        failures++;
        $display("FAIL grant got=adr %h exp=init%0d adr %h",
                 m_wb_adr, w, s_wb_adr[w*32 +: 32]);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); @(negedge clk);
        checks++;
        if (s_wb_ack !== 3'b000) begin
          failures++;
          $display("FAIL wait_ack got=%b exp=000", s_wb_ack);
        end
      end
      d = $urandom;
      m_wb_ack = 1'b1; m_wb_dat_i = d; #1;
      checks++;
      if (s_wb_ack !== 3'(1 << w) || s_wb_err !== 3'b000 ||
          s_wb_dat_o[w*32 +: 32] !== d) begin
        failures++;
        $display("FAIL ack got=%b/%h exp=%b/%h",
                 s_wb_ack, s_wb_dat_o[w*32 +: 32], 3'(1 << w), d);
      end
      @(posedge clk); #1;
      m_wb_ack = 1'b0;
      s_wb_cyc[w] = 1'b0; s_wb_stb[w] = 1'b0;
      @(negedge clk);
      checks++;
      if (m_wb_cyc !== 1'b0) begin
        failures++;
        $display("FAIL release got=%b exp=0", m_wb_cyc);
      end
      @(posedge clk); #1;
      m_last = w;
      req[w] = 1'b0;
    end
  endtask

  task automatic test_order();
    do_reset();
    serve(3'b111);
    serve(3'b101);
  endtask

  task automatic test_random();
    do_reset();
    repeat (8) serve(3'($urandom_range(1, 7)));
  endtask

  task automatic test_lock();
    logic [31:0] a1;
    int          w;
    do_reset();
    load_init(0); load_init(1);
    a1 = s_wb_adr[63:32];
    s_wb_cyc[0] = 1'b1; s_wb_stb[0] = 1'b1;
    @(posedge clk); #1;
    s_wb_cyc[1] = 1'b1; s_wb_stb[1] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      s_wb_adr[31:0] = {2'b00, 30'($urandom)};
      s_wb_stb[0] = 1'b1;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        checks++;
        if (m_wb_adr !== s_wb_adr[31:0] || m_wb_adr === a1) begin
          failures++;
          $display("FAIL lock_wait got=%h exp=%h", m_wb_adr, s_wb_adr[31:0]);
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      m_wb_ack = 1'b1; #1;
      checks++;
      if (s_wb_ack !== 3'b001 || m_wb_adr !== s_wb_adr[31:0]) begin
        failures++;
        $display("FAIL lock_ack got=%b/%h exp=001/%h",
                 s_wb_ack, m_wb_adr, s_wb_adr[31:0]);
      end
      @(posedge clk); #1;
      m_wb_ack = 1'b0; s_wb_stb[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (m_wb_cyc !== 1'b1 || m_wb_adr === a1) begin
        failures++;
        $display("FAIL lock_gap got=%b/%h exp=1/not %h", m_wb_cyc, m_wb_adr, a1);
      end
      @(posedge clk); #1;
    end
    s_wb_cyc[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (m_wb_cyc !== 1'b0) begin
      failures++;
      $display("FAIL lock_drop got=%b exp=0", m_wb_cyc);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (m_wb_cyc !== 1'b0) begin
      failures++;
      $display("FAIL lock_idle got=%b exp=0", m_wb_cyc);
    end
    @(posedge clk); @(negedge clk);
    w = rr_pick(0, 3'b010);
    checks++;
    if (m_wb_cyc !== 1'b1 || m_wb_adr !== s_wb_adr[w*32 +: 32]) begin
      failures++;
      $display("FAIL lock_next got=%b/%h exp=1/%h", m_wb_cyc, m_wb_adr, a1);
    end
  endtask

  task automatic test_watchdog();
    int          w;
    logic [2:0]  oh;
    do_reset();
    w  = $urandom_range(0, 2);
    oh = 3'(1 << w);
    s_wb_cyc[w] = 1'b1; s_wb_stb[w] = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (s_wb_err !== 3'b000 || m_wb_stb !== 1'b1) begin
        failures++;
        $display("FAIL wd_pre k=%0d got=%b/%b exp=000/1", k, s_wb_err, m_wb_stb);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (s_wb_err !== oh || m_wb_stb !== 1'b0 || m_wb_cyc !== 1'b1) begin
      failures++;
      $display("FAIL wd_hit got=%b/%b exp=%b/0", s_wb_err, m_wb_stb, oh);
    end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (s_wb_err !== 3'b000) begin
        failures++;
        $display("FAIL wd_post k=%0d got=%b exp=000", k, s_wb_err);
      end
    end
    @(posedge clk); #1;
    m_wb_ack = 1'b1; #1;
    checks++;
    if (s_wb_ack !== oh || s_wb_err !== 3'b000) begin
      failures++;
      $display("FAIL wd_ack got=%b/%b exp=%b/000", s_wb_ack, s_wb_err, oh);
    end
    @(posedge clk); #1;
    m_wb_ack = 1'b0;
  endtask

  task automatic test_err();
    logic [31:0] d;
    do_reset();
    s_wb_cyc[2] = 1'b1; s_wb_stb[2] = 1'b1; s_wb_we[2] = 1'b0;
    @(posedge clk); #1;
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(negedge clk);
    d = $urandom;
    m_wb_err = 1'b1; m_wb_dat_i = d; #1;
    checks++;
    if (s_wb_err !== 3'b100 || s_wb_ack !== 3'b000) begin
      failures++;
      $display("FAIL terr got=%b/%b exp=100/000", s_wb_err, s_wb_ack);
    end
    checks++;
    if (s_wb_dat_o !== {3{d}}) begin
      failures++;
      $display("FAIL bcast got=%h exp=%h", s_wb_dat_o, {3{d}});
    end
    @(posedge clk); #1;
    m_wb_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_wb_cyc[2] = 1'b1; s_wb_stb[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (m_wb_cyc !== 1'b1) begin
      failures++;
      $display("FAIL rmid_busy got=%b exp=1", m_wb_cyc);
    end
    #2;
    m_wb_ack = 1'b1;
    rst = 1'b1; #1;
    checks++;
    if (m_wb_cyc !== 1'b0 || m_wb_stb !== 1'b0 || s_wb_ack !== 3'b000) begin
      failures++;
      $display("FAIL rmid_async got=%b/%b/%b exp=0/0/000",
               m_wb_cyc, m_wb_stb, s_wb_ack);
    end
    m_wb_ack = 1'b0;
    s_wb_cyc = 3'b111; s_wb_stb = 3'b111;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_wb_cyc !== 1'b0) begin
      failures++;
      $display("FAIL rmid_idle got=%b exp=0", m_wb_cyc);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (m_wb_cyc !== 1'b1 || m_wb_adr !== s_wb_adr[31:0]) begin
      failures++;
      $display("FAIL rmid_first got=%h exp=%h", m_wb_adr, s_wb_adr[31:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_wb_adr = '0; s_wb_sel = '0; s_wb_we = '0; s_wb_dat_i = '0;
    s_wb_cyc = '0; s_wb_stb = '0;
    m_wb_dat_i = '0; m_wb_ack = 1'b0; m_wb_err = 1'b0;
    test_reset();
    test_latency();
    test_order();
    test_lock();
    test_watchdog();
    test_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
